seq_nonrestoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 30 +++
 rtl/seq_nonrestoring_divider_if.sv | 24 ++
 rtl/seq_nonrestoring_divider_nr_div_step.sv | 23 ++
 rtl/seq_nonrestoring_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_nonrestoring_divider.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StIter,
    StFixup
  } div_state_e;

  // Opcode encoding the control unit decodes into signed_mode when issuing a divide.
  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  localparam logic SignedModeDiv  = 1'b1;
  localparam logic SignedModeDivu = 1'b0;

  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic op_signed_mode(div_op_e op);
    return (op == OpDiv || op == OpRem) ? SignedModeDiv : SignedModeDivu;
  endfunction

endpackage

// File: rtl/seq_nonrestoring_divider_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface seq_nonrestoring_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_nonrestoring_divider_nr_div_step.sv
// One combinational non-restoring iteration: shift {A,Q} left, add or subtract M by
// the sign of the old A, and shift in the new quotient bit.
module nr_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] m_ext;

  always_comb begin
    a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
    m_ext = {1'b0, m_i};
    a_o   = a_i[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    q_o   = {q_i[WIDTH-2:0], ~a_o[WIDTH]};
  end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle signed/unsigned non-restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN short-circuits a zero divisor and raises div_by_zero.
module seq_nonrestoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic                       clock,
  input logic                       clear,
  seq_nonrestoring_divider_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic             sm_q, sm_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH:0]   a_q, a_d, a_step, a_fix;
  logic [WIDTH-1:0] q_q, q_d, q_step;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             sd, sv;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz_q, dz_d;
  logic             div_by_zero_q, div_by_zero_d;
`endif

  nr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a_i(a_q),
    .q_i(q_q),
    .m_i(m_q),
    .a_o(a_step),
    .q_o(q_step)
  );

  always_comb begin
    state_d     = state_q;
    sm_d        = sm_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    count_d     = count_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d          = dz_q;
    div_by_zero_d = div_by_zero_q;
`endif
    sd    = sm_q & dividend_q[WIDTH-1];
    sv    = sm_q & divisor_q[WIDTH-1];
    a_fix = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sm_d       = bus.signed_mode;
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        neg_quo_d = sd ^ sv;
        neg_rem_d = sd;
        a_d       = '0;
        q_d       = sd ? -dividend_q : dividend_q;
        m_d       = sv ? -divisor_q : divisor_q;
        count_d   = '0;
        state_d   = StIter;
`ifdef DIV_ZERO_DETECT_EN
        dz_d = (divisor_q == '0);
        if (dz_d) state_d = StFixup;
`endif
      end
      StIter: begin
        a_d     = a_step;
        q_d     = q_step;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) state_d = StFixup;
      end
      StFixup: begin
        quotient_d  = neg_quo_q ? -q_q : q_q;
        remainder_d = neg_rem_q ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
        div_by_zero_d = dz_q;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
        end
`endif
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // clear dominates everything, including a start in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      sm_q        <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q          <= 1'b0;
      div_by_zero_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sm_q        <= sm_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      count_q     <= count_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q          <= dz_d;
      div_by_zero_q <= div_by_zero_d;
`endif
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_by_zero = div_by_zero_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Scoreboard bench for seq_nonrestoring_divider at WIDTH=32 and WIDTH=8.
module tb_seq_nonrestoring_divider;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DzDetect = 1'b1;
`else
  localparam bit DzDetect = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  seq_nonrestoring_divider_if #(.WIDTH(W))  bus32 ();
  seq_nonrestoring_divider_if #(.WIDTH(W8)) bus8 ();

  seq_nonrestoring_divider #(.WIDTH(W)) dut32 (
    .clock(clock),
    .clear(clear),
    .bus  (bus32)
  );

  seq_nonrestoring_divider #(.WIDTH(W8)) dut8 (
    .clock(clock),
    .clear(clear),
    .bus  (bus8)
  );

  function automatic exp_t ref_div(input int unsigned w, input bit sm, input logic [31:0] dd,
                                   input logic [31:0] dv);
    exp_t   e;
    longint mask = (longint'(1) << w) - 1;
    longint sdd  = longint'(dd) & mask;
    longint sdv  = longint'(dv) & mask;
    longint qq, rr;
    if (sm && sdd[w-1]) sdd = sdd - (mask + 1);
    if (sm && sdv[w-1]) sdv = sdv - (mask + 1);
    e.dz = 1'b0;
    if (sdv == 0) begin
      if (DzDetect) begin
        qq   = mask;
        e.dz = 1'b1;
      end else begin
        qq = (sdd < 0) ? -mask : mask;
      end
      rr = sdd;
    end else begin
      qq = sdd / sdv;
      rr = sdd % sdv;
    end
    e.q = 32'(qq & mask);
    e.r = 32'(rr & mask);
    return e;
  endfunction

  function automatic int lat(input int unsigned w, input logic [31:0] dv);
    return (DzDetect && dv == 32'd0) ? 3 : int'(w) + 3;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start for one cycle; returns positioned in cycle 1 of the operation.
  task automatic issue32(input bit sm, input logic [31:0] dd, input logic [31:0] dv);
    bus32.start       = 1'b1;
    bus32.signed_mode = sm;
    bus32.dividend    = dd;
    bus32.divisor     = dv;
    sb.push_back(ref_div(W, sm, dd, dv));
    tick();
    bus32.start = 1'b0;
    check("busy_cycle1", bus32.busy, 1'b1);
  endtask

  task automatic finish32(input string tag, input int cyc0, input int exp_cyc);
    int   cyc = cyc0;
    exp_t e;
    while (bus32.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    check({tag, "_busy_at_done"}, bus32.busy, 1'b0);
    e = sb.pop_front();
    check({tag, "_q"}, bus32.quotient, e.q);
    check({tag, "_r"}, bus32.remainder, e.r);
    check({tag, "_dz"}, bus32.div_by_zero, e.dz);
  endtask

  task automatic op32(input string tag, input bit sm, input logic [31:0] dd,
                      input logic [31:0] dv);
    issue32(sm, dd, dv);
    finish32(tag, 1, lat(W, dv));
  endtask

  task automatic run8(input bit sm, input logic [7:0] dd, input logic [7:0] dv);
    int   cyc = 1;
    exp_t e;
    bus8.start       = 1'b1;
    bus8.signed_mode = sm;
    bus8.dividend    = dd;
    bus8.divisor     = dv;
    sb.push_back(ref_div(W8, sm, {24'd0, dd}, {24'd0, dv}));
    tick();
    bus8.start = 1'b0;
    while (bus8.done !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("w8_done_cycle", cyc, lat(W8, {24'd0, dv}));
    e = sb.pop_front();
    check("w8_q", bus8.quotient, e.q[7:0]);
    check("w8_r", bus8.remainder, e.r[7:0]);
    check("w8_dz", bus8.div_by_zero, e.dz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    clear             = 1'b1;
    bus32.start       = 1'b0;
    bus32.signed_mode = 1'b0;
    bus32.dividend    = '0;
    bus32.divisor     = '0;
    bus8.start        = 1'b0;
    bus8.signed_mode  = 1'b0;
    bus8.dividend     = '0;
    bus8.divisor      = '0;
    repeat (3) tick();
    check("rst_busy", bus32.busy, 1'b0);
    check("rst_done", bus32.done, 1'b0);
    check("rst_q", bus32.quotient, 32'd0);
    check("rst_r", bus32.remainder, 32'd0);
    check("rst_dz", bus32.div_by_zero, 1'b0);

    // clear with a simultaneous start must not launch an operation
    bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    clear       = 1'b0;
    check("clear_vs_start_busy", bus32.busy, 1'b0);
    tick();
    check("clear_vs_start_idle", bus32.busy, 1'b0);

    op32("s_100_7", 1'b1, 32'd100, 32'd7);
    tick();
    check("hold_done_low", bus32.done, 1'b0);
    check("hold_q", bus32.quotient, 32'd14);
    op32("s_m100_7", 1'b1, -32'sd100, 32'd7);
    op32("s_100_m7", 1'b1, 32'd100, -32'sd7);
    op32("s_m100_m7", 1'b1, -32'sd100, -32'sd7);
    op32("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
    op32("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    op32("s_7_0", 1'b1, 32'd7, 32'd0);
    op32("u_7_0", 1'b0, 32'd7, 32'd0);
    op32("s_m7_0", 1'b1, -32'sd7, 32'd0);

    // start in the done cycle is accepted
    op32("b2b_first", 1'b1, 32'd12345, -32'sd3);
    issue32(1'b0, 32'd1000000, 32'd33);
    finish32("b2b_second", 1, W + 3);

    // starts while busy are ignored
    issue32(1'b0, 32'd1000, 32'd9);
    for (int c = 1; c < 34; c++) begin
      bus32.start    = (c == 5 || c == 20);
      bus32.dividend = 32'd5;
      bus32.divisor  = 32'd1;
      tick();
    end
    bus32.start = 1'b0;
    finish32("ignored_starts", 34, W + 3);

    // abort mid-operation
    issue32(1'b1, 32'd100, 32'd7);
    void'(sb.pop_front());
    repeat (9) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", bus32.busy, 1'b0);
    check("abort_done", bus32.done, 1'b0);
    check("abort_q", bus32.quotient, 32'd0);
    check("abort_r", bus32.remainder, 32'd0);
    check("abort_dz", bus32.div_by_zero, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus32.done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] dd, dv;
      dd = $urandom;
      dv = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) dv = 32'd0;
      op32("rand32", 1'($urandom_range(0, 1)), dd, dv);
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] dd, dv;
      dd = 8'($urandom);
      dv = 8'($urandom);
      if (i == 0) begin
        dd = 8'h80;
        dv = 8'hFF;
      end
      if (i % 9 == 4) dv = 8'd0;
      run8(1'($urandom_range(0, 1)), dd, dv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
